// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 4-stage pipeline. It owns the program counter,
// issues reads to the synchronous instruction ROM (1-cycle read latency), and
// loads {pc, instr} into the IF/ID pipeline register for decode.
//
// Stall from the hazard unit holds the PC and the IF/ID register. The word
// already in flight from the ROM when a stall begins goes into a 1-entry skid
// buffer, so it is neither lost nor fetched twice. Flush redirects fetch to a
// branch/jump target, discards all in-flight state and has priority over stall.
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   stall        in   1   hold IF/ID register and PC
//   flush        in   1   redirect fetch to redirect_pc (wins over stall)
//   redirect_pc  in   32  branch/jump target; bits [1:0] are forced to 0
//   imem_addr    out  32  ROM read address (always the current PC)
//   imem_en      out  1   this cycle's ROM read is a real issue
//   imem_data    in   32  ROM read data, valid one cycle after its address
//   if_valid     out  1   IF/ID register holds a real instruction
//   if_pc        out  32  PC of if_instr
//   if_pc_plus4  out  32  if_pc + 4 (wraps mod 2^32)
//   if_instr     out  32  fetched instruction (NOP_INSTR when not valid)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0040_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_instr
);

   // What the stage does at the next edge, resolved with flush > stall > run.
   typedef enum logic [1:0] {
      MODE_RUN,
      MODE_STALL,
      MODE_FLUSH
   } mode_t;

   mode_t mode;

   // Fetch PC
   logic [31:0] pc_r;
   logic [31:0] pc_nxt;

   // Read issued last cycle; its data is on imem_data this cycle
   logic        rsp_valid;
   logic [31:0] rsp_pc;
   logic        rsp_valid_nxt;
   logic [31:0] rsp_pc_nxt;

   // Skid entry: in-flight word captured when a stall began
   logic        sk_valid;
   logic [31:0] sk_pc;
   logic [31:0] sk_instr;
   logic        sk_valid_nxt;
   logic [31:0] sk_pc_nxt;
   logic [31:0] sk_instr_nxt;

   // IF/ID register next values
   logic        if_valid_nxt;
   logic [31:0] if_pc_nxt;
   logic [31:0] if_instr_nxt;

   // Targets are word aligned; the low two redirect bits carry no information.
   logic        redirect_low_unused;
   assign redirect_low_unused = ^redirect_pc[1:0];

   // --------------------------------------------------------------------------
   // Mode decode
   // --------------------------------------------------------------------------
   always_comb begin
      if (flush) begin
         mode = MODE_FLUSH;
      end else if (stall) begin
         mode = MODE_STALL;
      end else begin
         mode = MODE_RUN;
      end
   end

   // --------------------------------------------------------------------------
   // ROM interface
   // --------------------------------------------------------------------------
   assign imem_addr   = pc_r;
   assign imem_en     = !reset && (mode == MODE_RUN);
   assign if_pc_plus4 = if_pc + 32'd4;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every signal gets a hold default before the case so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      pc_nxt        = pc_r;
      rsp_valid_nxt = rsp_valid;
      rsp_pc_nxt    = rsp_pc;
      sk_valid_nxt  = sk_valid;
      sk_pc_nxt     = sk_pc;
      sk_instr_nxt  = sk_instr;
      if_valid_nxt  = if_valid;
      if_pc_nxt     = if_pc;
      if_instr_nxt  = if_instr;

      unique case (mode)
         MODE_FLUSH: begin
            // Everything in flight belongs to the wrong path. The target is
            // issued next cycle, giving a two-cycle redirect bubble.
            pc_nxt        = {redirect_pc[31:2], 2'b00};
            rsp_valid_nxt = 1'b0;
            sk_valid_nxt  = 1'b0;
            if_valid_nxt  = 1'b0;
            if_instr_nxt  = NOP_INSTR;
         end

         MODE_STALL: begin
            // No issue while stalled, so at most the first stall cycle can
            // see a returning word; the single skid entry is always enough.
            rsp_valid_nxt = 1'b0;
            if (rsp_valid) begin
               sk_valid_nxt = 1'b1;
               sk_pc_nxt    = rsp_pc;
               sk_instr_nxt = imem_data;
            end
         end

         default: begin // MODE_RUN
            rsp_valid_nxt = 1'b1;
            rsp_pc_nxt    = pc_r;
            pc_nxt        = pc_r + 32'd4;

            // A valid skid entry is always older than any ROM response:
            // nothing was issued while it was being held.
            if (sk_valid) begin
               if_valid_nxt = 1'b1;
               if_pc_nxt    = sk_pc;
               if_instr_nxt = sk_instr;
               sk_valid_nxt = 1'b0;
            end else if (rsp_valid) begin
               if_valid_nxt = 1'b1;
               if_pc_nxt    = rsp_pc;
               if_instr_nxt = imem_data;
            end else begin
               if_valid_nxt = 1'b0;
               if_instr_nxt = NOP_INSTR;
            end
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_r      <= PC_RESET;
         rsp_valid <= 1'b0;
         rsp_pc    <= '0;
         sk_valid  <= 1'b0;
         sk_pc     <= '0;
         sk_instr  <= '0;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_instr  <= NOP_INSTR;
      end else begin
         pc_r      <= pc_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_pc    <= rsp_pc_nxt;
         sk_valid  <= sk_valid_nxt;
         sk_pc     <= sk_pc_nxt;
         sk_instr  <= sk_instr_nxt;
         if_valid  <= if_valid_nxt;
         if_pc     <= if_pc_nxt;
         if_instr  <= if_instr_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A behavioural ROM returns a word derived from
// its address one cycle after an enabled read. The expected program-order PCs
// are queued when each scenario is set up and popped whenever a new
// instruction appears in the IF/ID register; stalled cycles must hold it.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] PC_RESET  = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_data = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instr;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];

   logic        prev_valid;
   logic [31:0] prev_pc;
   logic [31:0] prev_instr;

   fetch_stage #(
      .PC_RESET  (PC_RESET),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_en     (imem_en),
      .imem_data   (imem_data),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_pc_plus4 (if_pc_plus4),
      .if_instr    (if_instr)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous ROM with 1-cycle latency
   always @(posedge clock) begin
      if (imem_en) imem_data <= rom_word(imem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic save_prev();
      prev_valid = if_valid;
      prev_pc    = if_pc;
      prev_instr = if_instr;
   endtask

   // One clock: drive inputs, check imem_en, take the edge, then check the
   // IF/ID register against the hold rule or the scoreboard.
   task automatic cyc(input logic st, input logic fl, input logic [31:0] rd);
      stall       = st;
      flush       = fl;
      redirect_pc = rd;
      #1;
      chk("imem_en", {31'd0, imem_en}, {31'd0, !(st || fl)});
      @(posedge clock);
      #1;
      if (st && !fl) begin
         chk("hold_valid", {31'd0, if_valid}, {31'd0, prev_valid});
         chk("hold_pc", if_pc, prev_pc);
         chk("hold_instr", if_instr, prev_instr);
      end else if (if_valid) begin
         checks++;
         assert (exp_q.size() != 0)
         else begin
            errors++;
            $error("FAIL sb_underflow: observed pc %h, expected no instruction", if_pc);
         end
         if (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", if_pc, e);
            chk("sb_instr", if_instr, rom_word(e));
            chk("sb_pc_plus4", if_pc_plus4, e + 32'd4);
         end
      end else begin
         chk("bubble_instr", if_instr, NOP_INSTR);
      end
      save_prev();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
      chk({tag, "_pc"}, if_pc, 32'd0);
      chk({tag, "_instr"}, if_instr, NOP_INSTR);
      chk({tag, "_addr"}, imem_addr, PC_RESET);
      chk({tag, "_en"}, {31'd0, imem_en}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      @(posedge clock);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      exp_q.delete();
      save_prev();
   endtask

   task automatic sb_empty(input string tag);
      chk(tag, exp_q.size(), 32'd0);
   endtask

   initial begin
      // ---- 1: reset, startup sequence --------------------------------------
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(PC_RESET + 32'(4 * i));
      cyc(1'b0, 1'b0, '0);                       // E1: issue only
      chk("startup_e1_valid", {31'd0, if_valid}, 32'd0);
      cyc(1'b0, 1'b0, '0);                       // E2: first instruction
      chk("startup_e2_valid", {31'd0, if_valid}, 32'd1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);
      sb_empty("t1_sb_empty");

      // ---- 2: stall 3 cycles at if_pc = 0x00400008 --------------------------
      do_reset();
      for (int i = 0; i < 5; i++) exp_q.push_back(PC_RESET + 32'(4 * i));
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0);
      chk("t2_stall_at", if_pc, 32'h0040_0008);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);                       // skid drains 0x0040000C
      cyc(1'b0, 1'b0, '0);                       // 0x00400010 from ROM
      sb_empty("t2_sb_empty");

      // ---- 3: flush to 0x00400103 ------------------------------------------
      exp_q.push_back(32'h0040_0100);
      exp_q.push_back(32'h0040_0104);
      cyc(1'b0, 1'b1, 32'h0040_0103);
      chk("t3_addr_aligned", imem_addr, 32'h0040_0100);
      chk("t3_bubble1", {31'd0, if_valid}, 32'd0);
      cyc(1'b0, 1'b0, '0);
      chk("t3_bubble2", {31'd0, if_valid}, 32'd0);
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      sb_empty("t3_sb_empty");

      // ---- 4: stall + flush together, skid dropped -------------------------
      cyc(1'b1, 1'b0, '0);                       // skid captures in-flight word
      exp_q.push_back(32'h0040_0200);
      exp_q.push_back(32'h0040_0204);
      cyc(1'b1, 1'b1, 32'h0040_0200);
      chk("t4_flush_valid", {31'd0, if_valid}, 32'd0);
      chk("t4_flush_addr", imem_addr, 32'h0040_0200);
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, '0);
      chk("t4_addr_held", imem_addr, 32'h0040_0200);
      cyc(1'b0, 1'b0, '0);
      chk("t4_skid_dropped", {31'd0, if_valid}, 32'd0);
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      sb_empty("t4_sb_empty");

      // ---- 5: PC wrap -------------------------------------------------------
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      chk("t5_wrap_plus4", if_pc_plus4, 32'h0000_0000);
      cyc(1'b0, 1'b0, '0);
      sb_empty("t5_sb_empty");

      // ---- 6: async reset during a stall with a full skid -------------------
      cyc(1'b1, 1'b0, '0);                       // skid captured, stall held
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      do_reset();
      for (int i = 0; i < 3; i++) exp_q.push_back(PC_RESET + 32'(4 * i));
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0);
      sb_empty("t6_sb_empty");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
